digi_scan_ctrl: RTL and testbench

- Memory-mapped 7-segment display controller on the CPU data-memory bus.
- Software writes a 16-bit hex value and a control word.
- The block time-multiplexes the four digits and drives the 12-bit digi output bundle consumed at the CPU top level: {AN[3:0], DP, g..a}, all active-low.
- A raw mode lets software drive digi directly, for legacy programs.

---
 rtl/digi_scan_ctrl_pkg.sv | 45 ++++
 rtl/digi_scan_ctrl_seg7_hex_decode.sv | 14 +
 rtl/digi_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_digi_scan_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/digi_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller: register map,
// control-word field positions, the blank output word and the hex glyph table.
package digi_scan_ctrl_pkg;

  // Register byte offsets from the block base address
  localparam logic [31:0] OFF_VAL  = 32'h0;
  localparam logic [31:0] OFF_CTRL = 32'h4;
  localparam logic [31:0] OFF_RAW  = 32'h8;

  // CTRL field positions
  localparam int CTRL_EN        = 0;
  localparam int CTRL_RAW_MODE  = 1;
  localparam int CTRL_DP_LSB    = 2;
  localparam int CTRL_BLANK_LSB = 6;
  localparam int CTRL_W         = 10;

  localparam int VAL_W  = 16;
  localparam int RAW_W  = 12;
  localparam int DIGI_W = 12;

  // All anodes, DP and segments inactive (everything is active-low)
  localparam logic [DIGI_W-1:0] DIGI_OFF = 12'hFFF;

  // Active-low glyphs, bit order g..a, indexed by the hex nibble
  localparam logic [6:0] HEX7 [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Digit currently being driven; digit 0 is the rightmost
  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_e;

  // Next digit in the scan rotation, 3 wraps back to 0
  function automatic digit_e next_digit(input digit_e cur);
    return digit_e'(cur + 2'd1);
  endfunction

endpackage

// File: rtl/digi_scan_ctrl_seg7_hex_decode.sv
// Hex nibble to active-low 7-segment glyph (g..a), purely combinational.
module seg7_hex_decode
  import digi_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Straight table lookup; the table lives in the package so it has one owner
  always_comb begin
    seg = HEX7[nibble];
  end

endmodule

// File: rtl/digi_scan_ctrl.sv
// Memory-mapped 4-digit 7-segment controller.
// VAL holds four hex digits, CTRL selects enable/raw mode and the DP and blank
// masks, RAW is copied straight to the output in raw mode. The display is
// time-multiplexed one digit per SCAN_DIV clocks; digi is fully registered.
//
// Scan states:
//   state | meaning
//   DIG0  | driving digit 0 (rightmost, VAL[3:0]); also the idle/hold state
//   DIG1  | driving digit 1 (VAL[7:4])
//   DIG2  | driving digit 2 (VAL[11:8])
//   DIG3  | driving digit 3 (VAL[15:12]), wraps to DIG0
module digi_scan_ctrl
  import digi_scan_ctrl_pkg::*;
#(
  parameter int          SCAN_DIV  = 100000,
  parameter logic [31:0] BASE_ADDR = 32'h40000010
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MemWrite,
  input  logic                 MemRead,
  input  logic [31:0]          Address,
  input  logic [31:0]          WriteData,
  output logic [31:0]          ReadData,
  output logic                 hit,
  output logic [DIGI_W-1:0]    digi
);

  // A one-cycle slot still needs a 1-bit counter so the width never collapses
  localparam int              PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [31:0]     BASE_WORD  = BASE_ADDR & 32'hFFFF_FFFC;

  logic [VAL_W-1:0]  val_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [RAW_W-1:0]  raw_q;

  logic [31:0]       word_addr;
  logic              sel_val;
  logic              sel_ctrl;
  logic              sel_raw;

  logic              en;
  logic              raw_mode;
  logic              scan_on;
  logic [3:0]        dp_mask;
  logic [3:0]        blank_mask;

  logic [PW-1:0]     presc_q;
  digit_e            state_q;
  logic [1:0]        idx;
  logic [3:0]        cur_nib;
  logic [6:0]        cur_seg;

  // Byte-lane bits are ignored, so decode on the word-aligned address
  always_comb begin
    word_addr = Address & 32'hFFFF_FFFC;
    sel_val   = (word_addr == BASE_WORD + OFF_VAL);
    sel_ctrl  = (word_addr == BASE_WORD + OFF_CTRL);
    sel_raw   = (word_addr == BASE_WORD + OFF_RAW);
    hit       = sel_val | sel_ctrl | sel_raw;
  end

  // Read mux returns the pre-edge value, so a same-cycle write reads old data
  always_comb begin
    ReadData = 32'h0;
    if (MemRead) begin
      if (sel_val) begin
        ReadData = {{(32-VAL_W){1'b0}}, val_q};
      end else if (sel_ctrl) begin
        ReadData = {{(32-CTRL_W){1'b0}}, ctrl_q};
      end else if (sel_raw) begin
        ReadData = {{(32-RAW_W){1'b0}}, raw_q};
      end
    end
  end

  // Software-visible registers; bits beyond each register's width are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q  <= '0;
      ctrl_q <= '0;
      raw_q  <= '0;
    end else if (MemWrite) begin
      if (sel_val) begin
        val_q <= VAL_W'(WriteData);
      end
      if (sel_ctrl) begin
        ctrl_q <= CTRL_W'(WriteData);
      end
      if (sel_raw) begin
        raw_q <= RAW_W'(WriteData);
      end
    end
  end

  // Control-word fields; raw mode wins over enable
  always_comb begin
    en         = ctrl_q[CTRL_EN];
    raw_mode   = ctrl_q[CTRL_RAW_MODE];
    dp_mask    = ctrl_q[CTRL_DP_LSB +: 4];
    blank_mask = ctrl_q[CTRL_BLANK_LSB +: 4];
    scan_on    = en & ~raw_mode;
  end

  // Pick the nibble for the digit currently on the scan
  always_comb begin
    idx     = state_q;
    cur_nib = val_q[{idx, 2'b00} +: 4];
  end

  seg7_hex_decode u_hex_decode (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  // Prescaler, digit FSM and output register; outside normal scan the counter
  // and digit are held at zero so re-enabling always starts a full digit-0 slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      state_q <= DIG0;
      digi    <= DIGI_OFF;
    end else begin
      if (!scan_on) begin
        presc_q <= '0;
        state_q <= DIG0;
      end else if (presc_q == PRESC_LAST) begin
        presc_q <= '0;
        state_q <= next_digit(state_q);
      end else begin
        presc_q <= presc_q + PW'(1);
      end

      if (raw_mode) begin
        digi <= raw_q;
      end else if (!en) begin
        digi <= DIGI_OFF;
      end else if (blank_mask[idx]) begin
        digi <= DIGI_OFF;
      end else begin
        digi <= {~(4'b0001 << idx), ~dp_mask[idx], cur_seg};
      end
    end
  end

endmodule

// File: tb/tb_digi_scan_ctrl.sv
// Scoreboard bench for digi_scan_ctrl with SCAN_DIV=4. Stimulus pushes the
// expected value and the cycle it must appear; a negedge monitor pops and checks.
module tb_digi_scan_ctrl;

  localparam logic [31:0] BASE = 32'h40000010;
  localparam int K_DIGI = 0;
  localparam int K_RD   = 1;
  localparam int K_HIT  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        hit;
  logic [11:0] digi;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t        sb[$];
  int          cyc    = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] act;

  digi_scan_ctrl #(.SCAN_DIV(4), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .hit       (hit),
    .digi      (digi)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          K_DIGI:  act = {20'h0, digi};
          K_RD:    act = ReadData;
          default: act = {31'h0, hit};
        endcase
        checks++;
        if (act !== sb[i].exp) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h expected=%h", sb[i].name, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic push(input int at, input int kind, input logic [31:0] e, input string nm);
    chk_t c;
    c.cyc = at; c.kind = kind; c.exp = e; c.name = nm;
    sb.push_back(c);
  endtask

  task automatic exp_digi(input int at, input logic [11:0] e, input string nm);
    push(at, K_DIGI, {20'h0, e}, nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    Address = a; WriteData = d; MemWrite = 1'b1;
    step();
    MemWrite = 1'b0; Address = 32'h0; WriteData = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] e, input logic eh, input string nm);
    Address = a; MemRead = 1'b1;
    push(cyc, K_RD, e, nm);
    push(cyc, K_HIT, {31'h0, eh}, {nm, "_hit"});
    step();
    MemRead = 1'b0; Address = 32'h0;
  endtask

  initial begin
    int w;
    reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; Address = 32'h0; WriteData = 32'h0;

    exp_digi(1, 12'hFFF, "rst_digi_c1");
    exp_digi(2, 12'hFFF, "rst_digi_c2");
    step(); step();
    reset = 1'b0;
    checks++;
    if (digi !== 12'hFFF) begin
      errors++;
      $display("FAIL direct_rst_release_digi got=%h expected=fff", digi);
    end
    exp_digi(3, 12'hFFF, "post_rst_digi_c3");
    exp_digi(4, 12'hFFF, "post_rst_digi_c4");
    bus_read(BASE,     32'h0, 1'b1, "rst_val");
    bus_read(BASE + 4, 32'h0, 1'b1, "rst_ctrl");
    bus_read(BASE + 8, 32'h0, 1'b1, "rst_raw");

    bus_write(BASE, 32'h1234);
    bus_write(BASE + 4, 32'h1);
    w = cyc;
    for (int k = 1; k <= 4; k++) begin
      exp_digi(w + k,      12'hE99, "scan_d0_4");
      exp_digi(w + k + 4,  12'hDB0, "scan_d1_3");
      exp_digi(w + k + 8,  12'hBA4, "scan_d2_2");
      exp_digi(w + k + 12, 12'h7F9, "scan_d3_1");
    end
    wait_until(w + 15);
    bus_write(BASE, 32'h5678);
    exp_digi(w + 17, 12'hE80, "wrap_write_d0_8");
    exp_digi(w + 20, 12'hE80, "wrap_write_d0_hold");
    exp_digi(w + 21, 12'hDF8, "wrap_write_d1_7");
    wait_until(w + 22);

    bus_write(BASE + 4, 32'h0);
    bus_write(BASE, 32'h8888);
    bus_write(BASE + 4, 32'h105);
    w = cyc;
    exp_digi(w, 12'hFFF, "mask_prev_disabled");
    for (int k = 1; k <= 4; k++) begin
      exp_digi(w + k,      12'hE00, "mask_d0_dp");
      exp_digi(w + k + 4,  12'hD80, "mask_d1");
      exp_digi(w + k + 8,  12'hFFF, "mask_d2_blank");
      exp_digi(w + k + 12, 12'h780, "mask_d3");
    end
    wait_until(w + 17);

    bus_write(BASE + 8, 32'hABC);
    bus_write(BASE + 4, 32'h2);
    w = cyc;
    exp_digi(w + 1, 12'hABC, "raw_c1");
    exp_digi(w + 3, 12'hABC, "raw_c3");
    wait_until(w + 3);
    checks++;
    if (digi !== 12'hABC) begin
      errors++;
      $display("FAIL direct_raw_mode_digi got=%h expected=abc", digi);
    end
    bus_write(BASE + 4, 32'h1);
    w = cyc;
    exp_digi(w,     12'hABC, "raw_exit_edge");
    exp_digi(w + 1, 12'hE80, "raw_exit_d0_first");
    exp_digi(w + 4, 12'hE80, "raw_exit_d0_last");
    exp_digi(w + 5, 12'hD80, "raw_exit_d1");
    wait_until(w + 6);

    bus_write(BASE + 4, 32'hFFFF_FFFF);
    bus_read(BASE + 4,  32'h3FF, 1'b1, "ctrl_all_ones");
    checks++;
    if (digi !== 12'hABC) begin
      errors++;
      $display("FAIL direct_raw_override_digi got=%h expected=abc", digi);
    end
    bus_read(BASE + 12, 32'h0,   1'b0, "unmapped_read");
    bus_read(BASE - 4,  32'h0,   1'b0, "below_base_read");
    bus_write(BASE + 12, 32'hDEAD_BEEF);
    bus_read(BASE + 3,  32'h8888, 1'b1, "val_lowbits_ignored");
    bus_read(BASE + 4,  32'h3FF,  1'b1, "ctrl_after_unmapped");
    bus_read(BASE + 8,  32'hABC,  1'b1, "raw_after_unmapped");
    exp_digi(cyc, 12'hABC, "raw_override_en");
    Address = BASE; MemRead = 1'b0;
    push(cyc, K_RD, 32'h0, "no_memread_zero");
    push(cyc, K_HIT, 32'h1, "no_memread_hit");
    step();
    bus_write(BASE + 8, 32'hFFFF_F5A5);
    exp_digi(cyc + 1, 12'h5A5, "raw_new_value");
    bus_read(BASE + 8, 32'h5A5, 1'b1, "raw_upper_dropped");
    Address = BASE; WriteData = 32'h4321; MemWrite = 1'b1; MemRead = 1'b1;
    push(cyc, K_RD, 32'h8888, "rw_same_cycle_old");
    step();
    MemWrite = 1'b0; MemRead = 1'b0;
    bus_read(BASE, 32'h4321, 1'b1, "rw_committed");

    bus_write(BASE + 4, 32'h1);
    repeat (6) step();
    reset = 1'b1; Address = BASE; WriteData = 32'h9999; MemWrite = 1'b1;
    exp_digi(cyc, 12'hFFF, "rst_async_immediate");
    #1;
    checks++;
    if (digi !== 12'hFFF) begin
      errors++;
      $display("FAIL direct_async_reset_digi got=%h expected=fff", digi);
    end
    step();
    reset = 1'b0; MemWrite = 1'b0; Address = 32'h0; WriteData = 32'h0;
    w = cyc;
    for (int k = 0; k <= 6; k++) exp_digi(w + k, 12'hFFF, "rst_no_scan");
    bus_read(BASE,     32'h0, 1'b1, "rst_val_lost_write");
    bus_read(BASE + 4, 32'h0, 1'b1, "rst_ctrl_cleared");
    wait_until(w + 7);
    bus_write(BASE + 4, 32'h1);
    w = cyc;
    exp_digi(w + 1, 12'hEC0, "rescan_d0_0");
    exp_digi(w + 4, 12'hEC0, "rescan_d0_last");
    exp_digi(w + 5, 12'hDC0, "rescan_d1_0");
    wait_until(w + 7);

    repeat (2) step();
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL pending_%s due_cyc=%0d got=unchecked expected=%h", sb[0].name, sb[0].cyc, sb[0].exp);
      sb.delete(0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
